// File: rtl/debounce_edge_detect_pkg.sv
// Shared types and default parameters for the debounce/edge-detect input stage.
package debounce_edge_detect_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_CNT_W         = 4;
  localparam int DEF_STABLE_CYCLES = 8;

endpackage

// File: rtl/debounce_edge_detect_sync_chain.sv
// Parameterised flop-chain synchronizer for a single asynchronous input.
module debounce_edge_detect_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] s_q;
  logic [STAGES-1:0] s_d;

  // First stage captures the raw input directly; nothing may sit in front of it.
  always_comb begin
    s_d = {s_q[STAGES-2:0], din};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign dout = s_q[STAGES-1];

endmodule

// File: rtl/debounce_edge_detect.sv
// Synchronizes a bouncy input, qualifies level changes over a stable run of
// cycles, and emits one-cycle rise/fall pulses when the clean level moves.
//
// state    | meaning
// ST_IDLE  | synchronized input matches q, nothing being qualified
// ST_COUNT | synchronized input differs from q, counting stable samples
module debounce_edge_detect
  import debounce_edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic d_raw,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $fatal(1, "debounce_edge_detect: SYNC_STAGES must be 2..4");
  end
  if (STABLE_CYCLES < 2 || STABLE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_stable
    $fatal(1, "debounce_edge_detect: STABLE_CYCLES out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic       s_out;
  state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       q_q, q_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  debounce_edge_detect_sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .din  (d_raw),
    .dout (s_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (s_out != q_q) begin
          state_d = ST_COUNT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_COUNT: begin
        // A match at any point, including the terminal sample, rejects the change.
        if (s_out == q_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          q_d     = s_out;
          rise_d  = s_out;
          fall_d  = ~s_out;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == ST_COUNT);

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Self-checking bench: vector table, hand-written corner sequences, and
// randomized stimulus against a sample-history reference model.
module tb_debounce_edge_detect;

  localparam int SYNC   = 2;
  localparam int CNTW   = 4;
  localparam int STABLE = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic d_raw = 1'b0;
  logic q, rise, fall, busy;

  int errors = 0;
  int checks = 0;

  debounce_edge_detect #(
    .SYNC_STAGES  (SYNC),
    .CNT_W        (CNTW),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .d_raw(d_raw),
    .q    (q),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Reference model: synchronizer as a delay line, clean level flips once the
  // last STABLE synchronized samples all disagree with it.
  bit sync_m[SYNC];
  bit hist[$];
  bit mq, mrise, mfall, mbusy;

  task automatic model_edge(input bit r, input bit d);
    bit s;
    int run;
    if (r) begin
      for (int i = 0; i < SYNC; i++) sync_m[i] = 1'b0;
      hist.delete();
      mq = 0; mrise = 0; mfall = 0; mbusy = 0;
      return;
    end
    s = sync_m[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) sync_m[i] = sync_m[i-1];
    sync_m[0] = d;
    hist.push_back(s);
    if (hist.size() > 16) void'(hist.pop_front());
    mrise = 0; mfall = 0;
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != mq) run++;
      else break;
    end
    if (run >= STABLE) begin
      mq = s; mrise = s; mfall = !s; run = 0;
    end
    mbusy = (run > 0);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic d);
    reset = r;
    d_raw = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    chk("model_q", q, mq);
    chk("model_rise", rise, mrise);
    chk("model_fall", fall, mfall);
    chk("model_busy", busy, mbusy);
  endtask

  typedef struct {
    logic rst;
    logic d;
    logic q;
    logic rise;
    logic fall;
    logic busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic d, logic eq, logic er, logic ef, logic eb);
    vec_t v;
    v.rst = r; v.d = d; v.q = eq; v.rise = er; v.fall = ef; v.busy = eb;
    return v;
  endfunction

  int nrise, nfall;

  initial begin
    // Reset held with d_raw=1, release with d_raw=0, then a clean 0->1.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 12; k++)
      vecs.push_back(mk(0, 1, k >= 10, k == 10, 0, k >= 3 && k <= 9));

    #2;
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].d);
      chk("tbl_q", q, vecs[i].q);
      chk("tbl_rise", rise, vecs[i].rise);
      chk("tbl_fall", fall, vecs[i].fall);
      chk("tbl_busy", busy, vecs[i].busy);
    end

    // Clean 1->0: fall on edge 10 only.
    for (int k = 1; k <= 12; k++) begin
      step(0, 0);
      chk("fall_q", q, k < 10);
      chk("fall_pulse", fall, k == 10);
      chk("fall_no_rise", rise, 1'b0);
    end

    // Five-cycle glitch is rejected.
    nrise = 0; nfall = 0;
    for (int k = 1; k <= 5; k++) begin
      step(0, 1);
      nrise += int'(rise); nfall += int'(fall);
    end
    for (int k = 1; k <= 10; k++) begin
      step(0, 0);
      nrise += int'(rise); nfall += int'(fall);
    end
    chk("glitch_q", q, 1'b0);
    chk("glitch_busy", busy, 1'b0);
    chk("glitch_no_pulse", (nrise + nfall) == 0, 1'b1);

    // Seven matching samples then a reversal on the terminal sample.
    nrise = 0;
    for (int k = 1; k <= 7; k++) begin
      step(0, 1);
      nrise += int'(rise);
    end
    for (int k = 1; k <= 10; k++) begin
      step(0, 0);
      nrise += int'(rise);
    end
    chk("terminal_rev_q", q, 1'b0);
    chk("terminal_rev_no_rise", nrise == 0, 1'b1);

    // Reset mid-qualification restarts the full latency.
    for (int k = 1; k <= 5; k++) step(0, 1);
    step(1, 1);
    chk("midreset_q", q, 1'b0);
    chk("midreset_busy", busy, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step(0, 1);
      chk("midreset_q_edge", q, k >= 10);
      chk("midreset_rise_edge", rise, k == 10);
    end

    // Chatter every 3 cycles, then hold 1.
    step(1, 0);
    for (int k = 0; k < 3; k++) step(0, 0);
    nrise = 0; nfall = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, ((i / 3) % 2) == 0);
      nrise += int'(rise); nfall += int'(fall);
    end
    chk("chatter_no_pulse", (nrise + nfall) == 0, 1'b1);
    nrise = 0;
    for (int k = 1; k <= 12; k++) begin
      step(0, 1);
      chk("chatter_rise_edge", rise, k == 10);
      nrise += int'(rise);
    end
    chk("chatter_one_rise", nrise == 1, 1'b1);

    // Randomized runs with occasional resets.
    begin
      int left;
      logic dv;
      left = 0;
      dv = 0;
      for (int i = 0; i < 2000; i++) begin
        if (left == 0) begin
          dv = $urandom_range(1, 0);
          left = $urandom_range(15, 1);
        end
        left--;
        step($urandom_range(99, 0) == 0, dv);
        chk("rand_not_both", rise & fall, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
